// File: rtl/pito_irq_ctrl.sv
// rtl/pito_irq_ctrl.sv - per-hart interrupt collector and trap-request generator for PITO
// Optional machine timer (mtime/mtimecmp/MTIP) is built only when PITO_IRQ_TIMER_EN is defined.
module pito_irq_ctrl #(
  parameter int NUM_HARTS      = 8,
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS),
  parameter int XPR_LEN        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HART_CNT_WIDTH-1:0] hart_id_i,
  input  logic [XPR_LEN-1:0]        mie_i,
  input  logic                      mstatus_mie_i,
  input  logic [NUM_HARTS-1:0]      mvu_irq_i,
  input  logic [NUM_HARTS-1:0]      ext_irq_i,
  input  logic [NUM_HARTS-1:0]      sw_irq_set_i,
  input  logic [NUM_HARTS-1:0]      sw_irq_clr_i,
  input  logic                      mtimecmp_we_i,
  input  logic [HART_CNT_WIDTH-1:0] mtimecmp_hart_i,
  input  logic                      mtimecmp_hi_i,
  input  logic [31:0]               mtimecmp_wdata_i,
  output logic [63:0]               mtime_o,
  output logic [XPR_LEN-1:0]        mip_o,
  output logic                      irq_valid_o,
  output logic [XPR_LEN-1:0]        irq_cause_o,
  output logic [HART_CNT_WIDTH-1:0] irq_hart_o,
  input  logic                      irq_ack_i
);

  localparam logic [XPR_LEN-1:0] CAUSE_MEI = XPR_LEN'(32'h8000_000B);
  localparam logic [XPR_LEN-1:0] CAUSE_MSI = XPR_LEN'(32'h8000_0003);
  localparam logic [XPR_LEN-1:0] CAUSE_MTI = XPR_LEN'(32'h8000_0007);
  localparam logic [XPR_LEN-1:0] CAUSE_MVI = XPR_LEN'(32'h8000_0010);

  logic [NUM_HARTS-1:0] msip_q;
  logic [NUM_HARTS-1:0] mvu_pend_q;
  logic [NUM_HARTS-1:0] mtip;
  logic [NUM_HARTS-1:0] mvu_clr;
  logic                 mvu_ack;
  logic [XPR_LEN-1:0]   enabled;
  logic                 req_valid;
  logic [XPR_LEN-1:0]   req_cause;
  logic                 unused_enabled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q <= '0;
    end else begin
      msip_q <= (msip_q & ~sw_irq_clr_i) | sw_irq_set_i;
    end
  end

  // Only an accepted MVU request retires the pending flag; a same-cycle pulse re-arms it.
  assign mvu_ack = irq_ack_i && irq_valid_o && (irq_cause_o == CAUSE_MVI);

  always_comb begin
    mvu_clr = '0;
    if (mvu_ack) begin
      mvu_clr[irq_hart_o] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvu_pend_q <= '0;
    end else begin
      mvu_pend_q <= (mvu_pend_q & ~mvu_clr) | mvu_irq_i;
    end
  end

`ifdef PITO_IRQ_TIMER_EN
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q [NUM_HARTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (mtimecmp_we_i) begin
        if (mtimecmp_hi_i) begin
          mtimecmp_q[mtimecmp_hart_i][63:32] <= mtimecmp_wdata_i;
        end else begin
          mtimecmp_q[mtimecmp_hart_i][31:0] <= mtimecmp_wdata_i;
        end
      end
    end
  end

  always_comb begin
    mtip = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtip[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  assign mtime_o = mtime_q;
`else
  logic unused_timer;

  assign unused_timer = ^{mtimecmp_we_i, mtimecmp_hart_i, mtimecmp_hi_i, mtimecmp_wdata_i};
  assign mtip         = '0;
  assign mtime_o      = '0;
`endif

  always_comb begin
    mip_o     = '0;
    mip_o[3]  = msip_q[hart_id_i];
    mip_o[7]  = mtip[hart_id_i];
    mip_o[11] = ext_irq_i[hart_id_i];
    mip_o[16] = mvu_pend_q[hart_id_i];
  end

  assign enabled        = mip_o & mie_i & {XPR_LEN{mstatus_mie_i}};
  assign unused_enabled = ^{enabled[XPR_LEN-1:17], enabled[15:12], enabled[10:8],
                            enabled[6:4], enabled[2:0]};

  always_comb begin
    req_valid = 1'b1;
    req_cause = '0;
    if (enabled[11]) begin
      req_cause = CAUSE_MEI;
    end else if (enabled[3]) begin
      req_cause = CAUSE_MSI;
    end else if (enabled[7]) begin
      req_cause = CAUSE_MTI;
    end else if (enabled[16]) begin
      req_cause = CAUSE_MVI;
    end else begin
      req_valid = 1'b0;
    end
  end

  // Re-evaluated every cycle: the barrel moves on, so a request is never held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_valid_o <= 1'b0;
      irq_cause_o <= '0;
      irq_hart_o  <= '0;
    end else begin
      irq_valid_o <= req_valid;
      irq_cause_o <= req_cause;
      irq_hart_o  <= hart_id_i;
    end
  end

endmodule

// File: tb/tb_pito_irq_ctrl.sv
// tb/tb_pito_irq_ctrl.sv - directed self-checking bench for pito_irq_ctrl
module tb_pito_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hart_id_i;
  logic [31:0] mie_i;
  logic        mstatus_mie_i;
  logic [7:0]  mvu_irq_i;
  logic [7:0]  ext_irq_i;
  logic [7:0]  sw_irq_set_i;
  logic [7:0]  sw_irq_clr_i;
  logic        mtimecmp_we_i;
  logic [2:0]  mtimecmp_hart_i;
  logic        mtimecmp_hi_i;
  logic [31:0] mtimecmp_wdata_i;
  logic [63:0] mtime_o;
  logic [31:0] mip_o;
  logic        irq_valid_o;
  logic [31:0] irq_cause_o;
  logic [2:0]  irq_hart_o;
  logic        irq_ack_i;

  int checks = 0;
  int errors = 0;

  pito_irq_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hart_id_i        (hart_id_i),
    .mie_i            (mie_i),
    .mstatus_mie_i    (mstatus_mie_i),
    .mvu_irq_i        (mvu_irq_i),
    .ext_irq_i        (ext_irq_i),
    .sw_irq_set_i     (sw_irq_set_i),
    .sw_irq_clr_i     (sw_irq_clr_i),
    .mtimecmp_we_i    (mtimecmp_we_i),
    .mtimecmp_hart_i  (mtimecmp_hart_i),
    .mtimecmp_hi_i    (mtimecmp_hi_i),
    .mtimecmp_wdata_i (mtimecmp_wdata_i),
    .mtime_o          (mtime_o),
    .mip_o            (mip_o),
    .irq_valid_o      (irq_valid_o),
    .irq_cause_o      (irq_cause_o),
    .irq_hart_o       (irq_hart_o),
    .irq_ack_i        (irq_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] exp_time;
    rst_n = 1'b0;
    hart_id_i = '0; mie_i = '0; mstatus_mie_i = 1'b0;
    mvu_irq_i = '0; ext_irq_i = '0; sw_irq_set_i = '0; sw_irq_clr_i = '0;
    mtimecmp_we_i = 1'b0; mtimecmp_hart_i = '0; mtimecmp_hi_i = 1'b0; mtimecmp_wdata_i = '0;
    irq_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", irq_valid_o); end
    checks++; if (irq_cause_o !== 32'h0) begin errors++; $display("FAIL rst_cause got %h want 0", irq_cause_o); end
    checks++; if (irq_hart_o !== 3'd0) begin errors++; $display("FAIL rst_hart got %0d want 0", irq_hart_o); end
    checks++; if (mtime_o !== 64'd0) begin errors++; $display("FAIL rst_mtime got %0d want 0", mtime_o); end
    checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL rst_mip got %h want 0", mip_o); end
    rst_n = 1'b1;
    mie_i = '1;
    mstatus_mie_i = 1'b1;
    for (int h = 0; h < 8; h++) begin
      hart_id_i = 3'(h);
      #1;
      checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL idle_mip hart %0d got %h want 0", h, mip_o); end
      tick();
      checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid hart %0d got %0b want 0", h, irq_valid_o); end
`ifdef PITO_IRQ_TIMER_EN
      exp_time = 64'(h + 1);
`else
      exp_time = 64'd0;
`endif
      checks++; if (mtime_o !== exp_time) begin errors++; $display("FAIL mtime_count got %0d want %0d", mtime_o, exp_time); end
    end
  endtask

  task automatic test_mvu();
    hart_id_i = 3'd2; mie_i = 32'h0001_0000; mstatus_mie_i = 1'b1;
    mvu_irq_i = 8'h04;
    tick();
    mvu_irq_i = 8'h00;
    #1;
    checks++; if (mip_o !== 32'h0001_0000) begin errors++; $display("FAIL mvu_mip got %h want 00010000", mip_o); end
    tick();
    checks++; if (irq_valid_o !== 1'b1) begin errors++; $display("FAIL mvu_valid got %0b want 1", irq_valid_o); end
    checks++; if (irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL mvu_cause got %h want 80000010", irq_cause_o); end
    checks++; if (irq_hart_o !== 3'd2) begin errors++; $display("FAIL mvu_hart got %0d want 2", irq_hart_o); end
    irq_ack_i = 1'b1;
    hart_id_i = 3'd3;
    tick();
    irq_ack_i = 1'b0;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL mvu_other_hart got %0b want 0", irq_valid_o); end
    hart_id_i = 3'd2;
    #1;
    checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL mvu_cleared_mip got %h want 0", mip_o); end
    tick();
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL mvu_after_ack got %0b want 0", irq_valid_o); end
  endtask

  task automatic test_priority();
    hart_id_i = 3'd5; mie_i = 32'h888; mstatus_mie_i = 1'b1;
    ext_irq_i = 8'h20; sw_irq_set_i = 8'h20;
    tick();
    sw_irq_set_i = 8'h00;
    #1;
    checks++; if (mip_o !== 32'h808) begin errors++; $display("FAIL prio_mip got %h want 00000808", mip_o); end
    tick();
    checks++; if (irq_cause_o !== 32'h8000_000B || irq_valid_o !== 1'b1) begin errors++; $display("FAIL prio_ext got valid %0b cause %h want 1 8000000b", irq_valid_o, irq_cause_o); end
    checks++; if (irq_hart_o !== 3'd5) begin errors++; $display("FAIL prio_hart got %0d want 5", irq_hart_o); end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++; if (mip_o !== 32'h808) begin errors++; $display("FAIL prio_ack_nonmvu got %h want 00000808", mip_o); end
    ext_irq_i = 8'h00;
    tick();
    checks++; if (irq_cause_o !== 32'h8000_0003 || irq_valid_o !== 1'b1) begin errors++; $display("FAIL prio_sw got valid %0b cause %h want 1 80000003", irq_valid_o, irq_cause_o); end
    sw_irq_clr_i = 8'h20;
    tick();
    sw_irq_clr_i = 8'h00;
    tick();
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL prio_sw_clr got %0b want 0", irq_valid_o); end
  endtask

  task automatic test_timer();
    logic [63:0] tgt;
    int first_mip;
    int first_valid;
    logic [31:0] cause_at_valid;
    hart_id_i = 3'd1; mie_i = 32'h80; mstatus_mie_i = 1'b1;
    tgt = mtime_o + 64'd20;
    mtimecmp_we_i = 1'b1; mtimecmp_hart_i = 3'd1;
    mtimecmp_hi_i = 1'b0; mtimecmp_wdata_i = tgt[31:0];
    tick();
    mtimecmp_hi_i = 1'b1; mtimecmp_wdata_i = tgt[63:32];
    tick();
    mtimecmp_we_i = 1'b0;
    first_mip = -1;
    first_valid = -1;
    cause_at_valid = '0;
    for (int k = 2; k <= 40; k++) begin
      if (first_mip < 0 && mip_o[7]) first_mip = k;
      if (first_valid < 0 && irq_valid_o) begin
        first_valid = k;
        cause_at_valid = irq_cause_o;
      end
      tick();
    end
`ifdef PITO_IRQ_TIMER_EN
    checks++; if (first_mip !== 20) begin errors++; $display("FAIL timer_mtip_cycle got %0d want 20", first_mip); end
    checks++; if (first_valid !== 21) begin errors++; $display("FAIL timer_valid_cycle got %0d want 21", first_valid); end
    checks++; if (cause_at_valid !== 32'h8000_0007) begin errors++; $display("FAIL timer_cause got %h want 80000007", cause_at_valid); end
`else
    checks++; if (first_mip !== -1) begin errors++; $display("FAIL timer_off_mtip got %0d want -1", first_mip); end
    checks++; if (first_valid !== -1) begin errors++; $display("FAIL timer_off_valid got %0d want -1", first_valid); end
    checks++; if (mtime_o !== 64'd0) begin errors++; $display("FAIL timer_off_mtime got %0d want 0", mtime_o); end
`endif
  endtask

  task automatic test_simultaneous();
    hart_id_i = 3'd3; mie_i = 32'h0001_0000; mstatus_mie_i = 1'b1;
    mvu_irq_i = 8'h08;
    tick();
    mvu_irq_i = 8'h00;
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_cause_o !== 32'h8000_0010 || irq_hart_o !== 3'd3) begin
      errors++; $display("FAIL simul_req got valid %0b cause %h hart %0d want 1 80000010 3", irq_valid_o, irq_cause_o, irq_hart_o);
    end
    irq_ack_i = 1'b1; mvu_irq_i = 8'h08; hart_id_i = 3'd0;
    tick();
    irq_ack_i = 1'b0; mvu_irq_i = 8'h00; hart_id_i = 3'd3;
    #1;
    checks++; if (mip_o[16] !== 1'b1) begin errors++; $display("FAIL simul_ack_pulse got %0b want 1", mip_o[16]); end
    sw_irq_set_i = 8'h10; sw_irq_clr_i = 8'h10; hart_id_i = 3'd4;
    tick();
    sw_irq_set_i = 8'h00; sw_irq_clr_i = 8'h00;
    #1;
    checks++; if (mip_o !== 32'h8) begin errors++; $display("FAIL simul_set_clr got %h want 00000008", mip_o); end
    sw_irq_clr_i = 8'h10;
    tick();
    sw_irq_clr_i = 8'h00;
    #1;
    checks++; if (mip_o !== 32'h0) begin errors++; $display("FAIL simul_clr got %h want 0", mip_o); end
  endtask

  task automatic test_mie_gate();
    logic [31:0] exp_mip;
`ifdef PITO_IRQ_TIMER_EN
    exp_mip = 32'h0001_0888;
`else
    exp_mip = 32'h0001_0808;
`endif
    hart_id_i = 3'd1; mie_i = '1; mstatus_mie_i = 1'b0;
    ext_irq_i = 8'h02; sw_irq_set_i = 8'h02; mvu_irq_i = 8'h02;
    tick();
    sw_irq_set_i = 8'h00; mvu_irq_i = 8'h00;
    tick();
    tick();
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL gate_valid got %0b want 0", irq_valid_o); end
    checks++; if (mip_o !== exp_mip) begin errors++; $display("FAIL gate_mip got %h want %h", mip_o, exp_mip); end
    mstatus_mie_i = 1'b1;
    tick();
    checks++; if (irq_valid_o !== 1'b1 || irq_cause_o !== 32'h8000_000B || irq_hart_o !== 3'd1) begin
      errors++; $display("FAIL gate_open got valid %0b cause %h hart %0d want 1 8000000b 1", irq_valid_o, irq_cause_o, irq_hart_o);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (irq_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", irq_valid_o); end
    checks++; if (irq_cause_o !== 32'h0) begin errors++; $display("FAIL midrst_cause got %h want 0", irq_cause_o); end
    checks++; if (irq_hart_o !== 3'd0) begin errors++; $display("FAIL midrst_hart got %0d want 0", irq_hart_o); end
    checks++; if (mip_o !== 32'h800) begin errors++; $display("FAIL midrst_mip got %h want 00000800", mip_o); end
    tick();
    rst_n = 1'b1;
    ext_irq_i = 8'h00;
    tick();
    checks++; if (mtime_o > 64'd1) begin errors++; $display("FAIL midrst_mtime got %0d want <=1", mtime_o); end
  endtask

  initial begin
    test_reset();
    test_mvu();
    test_priority();
    test_timer();
    test_simultaneous();
    test_mie_gate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pito_irq_ctrl.md
Name: pito_irq_ctrl

Overview:
- Per-hart interrupt source collector and trap-request generator for the 8-hart PITO barrel core.
- Gathers machine software, timer, external and MVU interrupt sources for every hart and maintains each hart's MIP image.
- Each cycle it evaluates the hart currently in the core's trap-check slot and presents a prioritised trap request carrying the mcause code.
- Sits between the MVU/platform interrupt wires and the core's CSR/trap stage.

Parameters:
- NUM_HARTS, 8, number of hardware threads.
- HART_CNT_WIDTH, $clog2(NUM_HARTS), hart index width.
- XPR_LEN, 32, data and CSR width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- hart_id_i  in  HART_CNT_WIDTH  hart occupying the trap-check slot this cycle.
- mie_i  in  32  MIE CSR of hart_id_i.
- mstatus_mie_i  in  1  mstatus.MIE of hart_id_i.
- mvu_irq_i  in  NUM_HARTS  per-hart MVU done pulses, one cycle wide.
- ext_irq_i  in  NUM_HARTS  per-hart external interrupt levels.
- sw_irq_set_i  in  NUM_HARTS  set MSIP of the hart.
- sw_irq_clr_i  in  NUM_HARTS  clear MSIP of the hart.
- mtimecmp_we_i  in  1  mtimecmp write strobe.
- mtimecmp_hart_i  in  HART_CNT_WIDTH  hart whose mtimecmp is written.
- mtimecmp_hi_i  in  1  0 selects the low word, 1 selects the high word.
- mtimecmp_wdata_i  in  32  write data for mtimecmp.
- mtime_o  out  64  free-running machine time.
- mip_o  out  32  MIP image of hart_id_i (combinational).
- irq_valid_o  out  1  trap request for irq_hart_o.
- irq_cause_o  out  32  mcause value for the request.
- irq_hart_o  out  HART_CNT_WIDTH  hart the request belongs to.
- irq_ack_i  in  1  core accepted the current request.

Behaviour:
- Reset values:
  - mtime = 0.
  - All mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - All MSIP and MVU-pending flags = 0.
  - irq_valid_o = 0, irq_cause_o = 0, irq_hart_o = 0.
  - Reset mid-request drops the request immediately; there is no ack obligation.
- mip_o bit mapping:
  - bit 3 = MSIP (software).
  - bit 7 = MTIP (timer).
  - bit 11 = MEIP (external).
  - bit 16 = MVIP (MVU).
  - All other bits read 0.
- MSIP[h]:
  - Set by sw_irq_set_i[h], cleared by sw_irq_clr_i[h].
  - If set and clear arrive in the same cycle, set wins.
- MEIP[h] = ext_irq_i[h], level, unlatched.
- MVU pending[h]:
  - Set on an mvu_irq_i[h] pulse and held until acknowledged.
  - Cleared only by irq_ack_i while irq_valid_o=1, irq_hart_o=h and irq_cause_o=32'h8000_0010.
  - If an ack and a new pulse arrive in the same cycle, the flag stays set.
- mtime:
  - Increments by 1 every cycle.
  - Wraps from 2^64-1 to 0 with no flag.
- MTIP[h] = (mtime >= mtimecmp[h]), unsigned 64-bit compare.
- mtimecmp writes update only the selected 32-bit half, effective the next cycle.
- Request evaluation for hart h = hart_id_i:
  - enabled = mip & mie_i, gated by mstatus_mie_i.
  - Fixed priority, highest first:
    - MEIP gives cause 32'h8000_000B.
    - MSIP gives cause 32'h8000_0003.
    - MTIP gives cause 32'h8000_0007.
    - MVIP gives cause 32'h8000_0010.
  - Exception cause codes are never generated here.
- Output timing and handshake:
  - Outputs are registered with 1-cycle latency: the request for hart_id_i sampled in cycle t appears in cycle t+1.
  - Outputs re-evaluate every cycle; there is no hold. The barrel rotates, so the core must ack in the same cycle the request is presented.
  - irq_ack_i with irq_valid_o=0 is ignored.
  - An ack on a non-MVU cause has no effect; those sources are cleared at their origin.

Optional Feature:
- Macro: PITO_IRQ_TIMER_EN.
- Defined: mtime counter, per-hart mtimecmp registers and MTIP logic are all present.
- Undefined:
  - No timer registers are built; mtime_o = 0.
  - mtimecmp writes are ignored.
  - MTIP is 0 for all harts.
  - Ports remain present so the interface is unchanged.

Test Plan:
- Reset, then hold hart_id_i=0..7 with every mie_i bit set -> irq_valid_o stays 0, mip_o=0, mtime_o counts 0,1,2,...
- Hart 2: mvu_irq_i[2] pulse, mie_i=32'h10000, mstatus_mie_i=1, hart_id_i=2 -> next cycle irq_valid_o=1, irq_cause_o=32'h8000_0010, irq_hart_o=2. After ack, the flag is cleared and the next hart-2 slot gives irq_valid_o=0.
- Hart 5: ext_irq_i[5]=1, MSIP[5] set, mie_i=32'h888 -> cause 32'h8000_000B. Drop ext_irq_i[5] -> cause 32'h8000_0003.
- Hart 1: write mtimecmp low word to mtime+20, high word to mtime's high word, mie_i=32'h80 -> MTIP asserts within one cycle of the compare and cause is 32'h8000_0007. With PITO_IRQ_TIMER_EN undefined -> never asserts.
- Simultaneous events:
  - Ack and a new mvu_irq_i[3] in the same cycle -> pending[3] remains 1.
  - sw_irq_set_i[4] and sw_irq_clr_i[4] in the same cycle -> MSIP[4]=1.
- mstatus_mie_i=0 with every source pending -> irq_valid_o=0 while mip_o still shows 32'h10888.
